// File: rtl/eth_tx_framer.sv
// GMII transmit framer: wraps a byte stream with preamble/SFD, pads short
// frames to MIN_FRAME, appends CRC-32 FCS and enforces the inter-frame gap.
module eth_tx_framer #(
  parameter int IFG_BYTES = 12,
  parameter int MIN_FRAME = 60
) (
  input  logic       gmii_tx_clk,
  input  logic       rst_n,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic       gmii_tx_en,
  output logic [7:0] gmii_txd,
  output logic       tx_busy,
  output logic       frame_done,
  output logic       underrun
);

  typedef enum logic [2:0] {IDLE, PRE, DATA, PAD, FCS, IFG} state_t;

  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
  localparam logic [11:0] MIN_LEN  = 12'(MIN_FRAME);
  localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 1);

  state_t      state;
  logic [10:0] byte_cnt;
  logic [31:0] crc;
  logic        crc_raw;
  logic [2:0]  sub_cnt;
  logic [7:0]  ifg_cnt;

  logic [11:0] cnt_inc;
  logic [10:0] cnt_sat;
  logic [31:0] crc_data;
  logic [31:0] crc_pad;
  logic [31:0] fcs_word;
  logic [7:0]  fcs_byte;
  logic        start_frame;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    return r;
  endfunction

  assign cnt_inc  = {1'b0, byte_cnt} + 12'd1;
  assign cnt_sat  = (&byte_cnt) ? byte_cnt : cnt_inc[10:0];
  assign crc_data = crc_step(crc, s_data);
  assign crc_pad  = crc_step(crc, 8'h00);
  // An underrun deliberately ships the uninverted register so the receiver sees a bad FCS.
  assign fcs_word = crc_raw ? crc : ~crc;
  assign fcs_byte = fcs_word[{sub_cnt[1:0], 3'b000} +: 8];

  // The last IFG cycle doubles as an IDLE sample so back-to-back gaps are exactly IFG_BYTES.
  assign start_frame = s_valid && ((state == IDLE) || ((state == IFG) && (ifg_cnt == IFG_LAST)));

  assign s_ready = (state == DATA);
  assign tx_busy = (state != IDLE);

  // NOTE: every register here is state, so all assignments are non-blocking and the
  // async reset clears the GMII outputs immediately, truncating any frame in flight.
  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gmii_tx_en <= 1'b0;
      gmii_txd   <= 8'h00;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      byte_cnt   <= '0;
      crc        <= CRC_INIT;
      crc_raw    <= 1'b0;
      sub_cnt    <= '0;
      ifg_cnt    <= '0;
    end else begin
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      if (start_frame) begin
        state      <= PRE;
        gmii_tx_en <= 1'b1;
        gmii_txd   <= 8'h55;
        sub_cnt    <= 3'd1;
        byte_cnt   <= '0;
        crc        <= CRC_INIT;
        crc_raw    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            gmii_tx_en <= 1'b0;
            gmii_txd   <= 8'h00;
          end
          PRE: begin
            if (sub_cnt == 3'd7) begin
              gmii_txd <= 8'hD5;
              state    <= DATA;
            end else begin
              gmii_txd <= 8'h55;
              sub_cnt  <= sub_cnt + 3'd1;
            end
          end
          DATA: begin
            if (s_valid) begin
              gmii_txd <= s_data;
              crc      <= crc_data;
              byte_cnt <= cnt_sat;
              if (s_last) begin
                sub_cnt <= 3'd0;
                state   <= (cnt_inc < MIN_LEN) ? PAD : FCS;
              end
            end else begin
              // Source starved: first FCS byte goes out now so tx_en stays contiguous.
              gmii_txd <= crc[7:0];
              crc_raw  <= 1'b1;
              underrun <= 1'b1;
              sub_cnt  <= 3'd1;
              state    <= FCS;
            end
          end
          PAD: begin
            gmii_txd <= 8'h00;
            crc      <= crc_pad;
            byte_cnt <= cnt_sat;
            if (cnt_inc >= MIN_LEN) state <= FCS;
          end
          FCS: begin
            if (sub_cnt == 3'd4) begin
              gmii_tx_en <= 1'b0;
              gmii_txd   <= 8'h00;
              frame_done <= 1'b1;
              ifg_cnt    <= '0;
              state      <= IFG;
            end else begin
              gmii_txd <= fcs_byte;
              sub_cnt  <= sub_cnt + 3'd1;
            end
          end
          IFG: begin
            if (ifg_cnt == IFG_LAST) state <= IDLE;
            else ifg_cnt <= ifg_cnt + 8'd1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed bench for eth_tx_framer: frames are captured off GMII and compared
// byte-for-byte against a locally built expected frame with a bitwise CRC-32.
module tb_eth_tx_framer;

  logic       gmii_tx_clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic       s_ready;
  logic       gmii_tx_en;
  logic [7:0] gmii_txd;
  logic       tx_busy;
  logic       frame_done;
  logic       underrun;

  int n_checks = 0;
  int n_pass = 0;

  eth_tx_framer dut (
    .gmii_tx_clk(gmii_tx_clk),
    .rst_n(rst_n),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_last(s_last),
    .s_ready(s_ready),
    .gmii_tx_en(gmii_tx_en),
    .gmii_txd(gmii_txd),
    .tx_busy(tx_busy),
    .frame_done(frame_done),
    .underrun(underrun)
  );

  always #4 gmii_tx_clk = ~gmii_tx_clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Bit-serial reference CRC, one input bit at a time.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic fb;
    r = c;
    for (int b = 0; b < 8; b++) begin
      fb = r[0] ^ d[b];
      r  = r >> 1;
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  function automatic logic [7:0] pay(input int base, input int i);
    return 8'(base + i * 37);
  endfunction

  // GMII monitor: records every tx_en burst and the idle gap that preceded it.
  logic [7:0] fr_data[$];
  int fr_start[$];
  int fr_len[$];
  int fr_gap[$];
  int cur_len = 0;
  int gap_len = 0;
  int done_cnt = 0;
  int under_cnt = 0;
  int ready_bad = 0;
  int idle_bad = 0;
  logic prev_en = 1'b0;

  always @(negedge gmii_tx_clk) begin
    if (gmii_tx_en) begin
      if (!prev_en) begin
        fr_start.push_back(fr_data.size());
        fr_gap.push_back(gap_len);
        cur_len = 0;
      end
      fr_data.push_back(gmii_txd);
      cur_len++;
      if (cur_len <= 7 && s_ready) ready_bad++;
    end else begin
      if (prev_en) fr_len.push_back(cur_len);
      gap_len = prev_en ? 1 : gap_len + 1;
      if (tx_busy && s_ready) ready_bad++;
      if (gmii_txd !== 8'h00) idle_bad++;
    end
    if (frame_done) done_cnt++;
    if (underrun) under_cnt++;
    prev_en = gmii_tx_en;
  end

  // Streams n bytes honouring s_ready; stop_at>=0 drops s_valid (or asserts reset) there.
  task automatic send(input int n, input int base, input int stop_at, input bit do_reset);
    int i = 0;
    int guard = 0;
    while (i < n) begin
      @(negedge gmii_tx_clk);
      #1;
      if (i == stop_at) begin
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (do_reset) begin
          rst_n = 1'b0;
          #1;
          check("rst_async_tx_en", 32'(gmii_tx_en), 32'd0);
          check("rst_async_busy", 32'(tx_busy), 32'd0);
          check("rst_async_ready", 32'(s_ready), 32'd0);
        end
        return;
      end
      s_valid = 1'b1;
      s_data  = pay(base, i);
      s_last  = (i == n - 1);
      if (s_ready) i++;
      guard++;
      if (guard > 2000) begin
        check("send_timeout", i, n);
        s_valid = 1'b0;
        return;
      end
    end
  endtask

  task automatic idle();
    @(negedge gmii_tx_clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_frames(input int k);
    int c = 0;
    while (fr_len.size() < k && c < 1000) begin
      @(negedge gmii_tx_clk);
      c++;
    end
    check($sformatf("frames_seen_%0d", k), fr_len.size(), k);
  endtask

  task automatic check_frame(input int idx, input int n, input int base, input int drop_at,
                             input int exp_len);
    logic [7:0] exp_q[$];
    logic [31:0] c;
    logic [31:0] fcs;
    logic [31:0] act_fcs;
    int m;
    int errs;
    int len;
    int st;
    if (idx >= fr_len.size()) return;
    c = 32'hFFFFFFFF;
    for (int k = 0; k < 7; k++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    m = (drop_at >= 0) ? drop_at : n;
    for (int k = 0; k < m; k++) begin
      exp_q.push_back(pay(base, k));
      c = crc_byte(c, pay(base, k));
    end
    if (drop_at < 0) begin
      while (exp_q.size() - 8 < 60) begin
        exp_q.push_back(8'h00);
        c = crc_byte(c, 8'h00);
      end
    end
    fcs = (drop_at >= 0) ? c : ~c;
    for (int k = 0; k < 4; k++) exp_q.push_back(fcs[8*k +: 8]);

    len = fr_len[idx];
    st  = fr_start[idx];
    check($sformatf("f%0d_len", idx), len, exp_len);
    errs = 0;
    for (int j = 0; j < exp_q.size(); j++) begin
      if (j >= len) errs++;
      else if (fr_data[st + j] !== exp_q[j]) errs++;
    end
    check($sformatf("f%0d_byte_errs", idx), errs, 0);
    act_fcs = 32'd0;
    if (len >= 4)
      for (int k = 0; k < 4; k++) act_fcs[8*k +: 8] = fr_data[st + len - 4 + k];
    check($sformatf("f%0d_fcs", idx), act_fcs, fcs);
  endtask

  initial begin
    string s;
    logic [31:0] c;
    int d0;
    int u0;

    #1 rst_n = 1'b0;
    repeat (2) @(negedge gmii_tx_clk);
    check("rst_tx_en", 32'(gmii_tx_en), 32'd0);
    check("rst_txd", 32'(gmii_txd), 32'd0);
    check("rst_ready", 32'(s_ready), 32'd0);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    #1 rst_n = 1'b1;

    s = "123456789";
    c = 32'hFFFFFFFF;
    for (int k = 0; k < s.len(); k++) c = crc_byte(c, s[k]);
    check("crc_model_check", ~c, 32'hCBF43926);

    // 64-byte frame, no padding
    send(64, 8'h10, -1, 1'b0);
    idle();
    wait_frames(1);
    check_frame(0, 64, 8'h10, -1, 76);

    // 10-byte frame, 50 pad bytes
    send(10, 8'h20, -1, 1'b0);
    idle();
    wait_frames(2);
    check_frame(1, 10, 8'h20, -1, 72);

    // single byte with s_last on first accept
    d0 = done_cnt;
    send(1, 8'h30, -1, 1'b0);
    idle();
    wait_frames(3);
    repeat (3) @(negedge gmii_tx_clk);
    check_frame(2, 1, 8'h30, -1, 72);
    check("f2_frame_done_once", done_cnt - d0, 1);

    // back-to-back frames with s_valid held high
    send(64, 8'h40, -1, 1'b0);
    send(10, 8'h50, -1, 1'b0);
    idle();
    wait_frames(5);
    check_frame(3, 64, 8'h40, -1, 76);
    check_frame(4, 10, 8'h50, -1, 72);
    if (fr_gap.size() >= 5) check("b2b_gap", fr_gap[4], 12);
    check("ready_low_pre_ifg", ready_bad, 0);

    // underrun after 20 bytes
    u0 = under_cnt;
    send(30, 8'h60, 20, 1'b0);
    idle();
    wait_frames(6);
    repeat (2) @(negedge gmii_tx_clk);
    check_frame(5, 30, 8'h60, 20, 32);
    check("underrun_pulse", under_cnt - u0, 1);

    // reset at payload byte 30, then a clean frame
    send(50, 8'h70, 30, 1'b1);
    repeat (3) @(negedge gmii_tx_clk);
    #1 rst_n = 1'b1;
    wait_frames(7);
    if (fr_len.size() >= 7) begin
      check("rst_partial_len", fr_len[6], 38);
      check("rst_partial_last", 32'(fr_data[fr_start[6] + 37]), 32'(pay(8'h70, 29)));
    end
    send(20, 8'h80, -1, 1'b0);
    idle();
    wait_frames(8);
    check_frame(7, 20, 8'h80, -1, 72);
    check("idle_bus_zero", idle_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/eth_tx_framer.md
ETH_TX_FRAMER -- requirements
Module: eth_tx_framer

Interface
REQ-001 Parameter IFG_BYTES, default 12, SHALL set the idle cycles between frames, legal range 1..255.
REQ-002 Parameter MIN_FRAME, default 60, SHALL set the minimum bytes before FCS, with zero-padding applied up to this count.
REQ-003 gmii_tx_clk  input  1  SHALL be the single clock (125 MHz GMII TX clock); all logic runs on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 s_data  input  8  SHALL carry the frame byte (destination MAC first), excluding preamble, SFD and FCS.
REQ-006 s_valid  input  1  SHALL be high when s_data is valid.
REQ-007 s_last  input  1  SHALL mark the final payload byte, qualified by s_valid.
REQ-008 s_ready  output  1  SHALL be high when the framer accepts a byte; transfer occurs when s_valid && s_ready.
REQ-009 gmii_tx_en  output  1  SHALL be the GMII transmit enable, registered.
REQ-010 gmii_txd  output  8  SHALL be the GMII transmit data, registered.
REQ-011 tx_busy  output  1  SHALL be high whenever state is not IDLE.
REQ-012 frame_done  output  1  SHALL be a one-cycle pulse on the first IFG cycle.
REQ-013 underrun  output  1  SHALL be a one-cycle pulse when s_valid drops mid-frame.

Function
REQ-014 The FSM SHALL have states IDLE, PRE, DATA, PAD, FCS, IFG.
REQ-015 In IDLE, s_valid sampled high at an edge SHALL move the FSM to PRE and register gmii_tx_en=1, gmii_txd=0x55 at that same edge; s_ready stays low, so the first byte is held.
REQ-016 PRE SHALL output 7 bytes of 0x55 followed by 1 byte of 0xD5; the FSM SHALL be in DATA during the 0xD5 output cycle.
REQ-017 s_ready SHALL be high only in DATA (combinational from state).
REQ-018 A byte accepted at edge k SHALL appear on gmii_txd in the cycle following edge k, with no bubbles between consecutive payload bytes.
REQ-019 An 11-bit byte counter SHALL count accepted and pad bytes, saturating at 2047; no maximum length is enforced.
REQ-020 When s_last is accepted with count < MIN_FRAME, the FSM SHALL enter PAD and emit 0x00 until count = MIN_FRAME, then enter FCS; otherwise it SHALL go directly to FCS.
REQ-021 CRC-32 SHALL use the reflected polynomial 0xEDB88320 with init 0xFFFFFFFF, computed over payload and pad bytes only.
REQ-022 FCS SHALL be ~crc, sent as 4 bytes, least-significant byte first.
REQ-023 The CRC SHALL be re-initialised on entry to PRE.
REQ-024 Underrun: in DATA, s_valid=0 before s_last SHALL pulse underrun, skip PAD, and send FCS as the bitwise complement of the correct FCS (i.e., the raw crc).
REQ-025 IFG SHALL hold gmii_tx_en=0 and gmii_txd=0x00 for exactly IFG_BYTES cycles, then enter IDLE.
REQ-026 s_valid during IFG SHALL be ignored; the earliest next PRE is the cycle after the IFG ends.
REQ-027 Outside frames, gmii_tx_en SHALL be 0 and gmii_txd SHALL be 0x00.
REQ-028 s_valid and s_last both high at the first DATA edge SHALL produce a 1-byte payload padded with MIN_FRAME-1 zeros.

Reset
REQ-029 rst_n low SHALL immediately force state=IDLE, gmii_tx_en=0, gmii_txd=0x00, s_ready=0, tx_busy=0, frame_done=0, underrun=0, counter=0, and crc=0xFFFFFFFF.
REQ-030 Reset asserted mid-frame SHALL abort the frame, produce no FCS, and leave the frame partially delivered on GMII.
REQ-031 After rst_n deasserts, the FSM SHALL start in IDLE with no IFG enforced.

Verification
REQ-032 A 64-byte stream with continuous s_valid SHALL produce tx_en high for 8+64+4=76 cycles, with 0x55×7 and 0xD5 first, and an FCS matching a software CRC-32 model (model verified to give 0xCBF43926 on ASCII "123456789").
REQ-033 A 10-byte payload SHALL yield 50 zero pad bytes, tx_en high for 72 cycles, and an FCS matching the model over 60 bytes.
REQ-034 A 1-byte payload with s_last on the first accepted byte SHALL produce 59 zeros, a correct FCS, and frame_done exactly once.
REQ-035 Back-to-back frames with s_valid held high SHALL show exactly 12 tx_en-low cycles between frames, and s_ready low throughout PRE and IFG.
REQ-036 Dropping s_valid after byte 20 SHALL pulse underrun for one cycle, emit no pad, and send FCS equal to the complement of the correct FCS over 20 bytes.
REQ-037 Asserting rst_n low at payload byte 30 SHALL drive tx_en=0 without waiting for a clock edge; the next frame after release SHALL be well-formed.
